sd_crc_lanes: RTL and testbench
===============================

Name: sd_crc_lanes

Overview:
Parametrised multi-lane CRC generator and checker for the SD data and command paths. There is one LFSR per data lane, and the CRC width and polynomial are configurable. It runs on the SD bit clock with a clock-enable instead of a gated strobe. It also sequences the CRC phase itself: in transmit it serialises the CRC onto the lanes after the data, and in receive it compares the incoming CRC bits and flags errors per lane.

Parameters:
LANES, 4, number of parallel data lanes (1, 4 or 8)
CRC_W, 16, CRC width in bits (16 for data, 7 for command)
POLY, 16'h1021, generator polynomial without the x^CRC_W term, CRC_W bits wide
LEN_W, 13, width of the data-length counter (data bits per lane)

Ports:
sd_clk  input  1  SD bit clock; all state changes on its rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; begins a block; ignored unless state is IDLE
dir  input  1  sampled at start: 0 = transmit/generate, 1 = receive/check
len  input  LEN_W  sampled at start: data bits per lane
bit_en  input  1  qualifies the current sd_clk cycle as a bit slot
dat_i  input  LANES  data bits (tx: payload to send; rx: lines from card)
dat_o  output  LANES  line drive value
dat_oe  output  1  line output enable
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse at end of the CRC phase
crc_ok  output  1  rx: all lanes matched; tx: always 1; valid from done until next start
crc_err_lane  output  LANES  per-lane sticky mismatch flags, rx only
crc_o  output  LANES*CRC_W  per-lane computed CRC, latched at end of DATA; lane l at [l*CRC_W +: CRC_W]

Behaviour:
- Reset (async, rst high):
  - State is IDLE and all LFSRs are 0.
  - crc_o = 0, crc_err_lane = 0, crc_ok = 1, done = 0, busy = 0, dat_oe = 0, dat_o = all ones.
  - Reset mid-block aborts the block with no done pulse.
- LFSR step, per lane and only on bit_en:
  - inv = bit ^ crc[CRC_W-1]
  - crc <= {crc[CRC_W-2:0], 1'b0} ^ (inv ? POLY : 0)
  - For POLY = 16'h1021 this gives CRC-16-CCITT with zero initial value.
- States: IDLE, DATA, CRC_TX, CRC_RX, DONE.
- IDLE:
  - On start: clear LFSRs and crc_err_lane, latch dir, load cnt = len.
  - If len != 0, go to DATA.
  - If len == 0, copy the all-zero LFSRs into crc_o and go straight to CRC_TX or CRC_RX with ccnt = CRC_W.
- DATA:
  - Each bit_en: step every lane with dat_i[l] and decrement cnt.
  - On the bit_en where cnt == 1, crc_o takes the post-step LFSR values.
  - On that same bit_en, go to CRC_TX (dir = 0) or CRC_RX (dir = 1) with ccnt = CRC_W.
  - Cycles without bit_en hold all state.
  - A start pulse in the same cycle as entering DATA does not consume a bit. The first data bit is the first bit_en seen while in DATA.
- CRC_TX:
  - dat_o[l] = LFSR[l][CRC_W-1].
  - Each bit_en: shift LFSR left, filling with 0, and decrement ccnt.
  - After CRC_W bit slots, go to DONE.
- CRC_RX:
  - Each bit_en: if dat_i[l] != LFSR[l][CRC_W-1], set crc_err_lane[l].
  - Then shift and decrement ccnt.
  - After CRC_W bit slots, go to DONE.
- DONE:
  - done = 1 for exactly one sd_clk cycle, independent of bit_en.
  - crc_ok = ~|crc_err_lane is updated in this cycle.
  - Next state is IDLE. start is ignored while in DONE.
- dat_o / dat_oe:
  - Combinational from state.
  - tx DATA: dat_o = dat_i.
  - CRC_TX: dat_o = CRC MSBs.
  - Otherwise dat_o = all ones (idle-high line).
  - dat_oe = 1 only in DATA or CRC_TX when dir = 0.
  - The start bit and end bit are framed by the caller, not this block.
- Latency:
  - Block takes len + CRC_W bit slots plus one DONE cycle.
  - Back-to-back blocks need start no earlier than the cycle after done.
- start while busy: ignored, with no effect on the counters.

Decomposition:
- Package sd_crc_pkg:
  - state enum: IDLE, DATA, CRC_TX, CRC_RX, DONE
  - constants CRC16_POLY = 16'h1021, CRC7_POLY = 7'h09
  - DIR_TX = 0, DIR_RX = 1
- Sub-module sd_crc_lfsr:
  - one lane, parameters CRC_W and POLY
  - ports sd_clk, rst, clr, step, shift, bit_in, crc
  - instantiated LANES times in a generate loop
- The FSM, counters and compare logic stay in the top level.

Test Plan:
- LANES=4, dir=0, len=4096, dat_i=4'hF on every bit_en -> each crc_o lane = 16'h7FA1; next 16 slots emit that value MSB-first on each lane; done pulses once.
- CRC_W=7, POLY=7'h09, LANES=1, tx of 40-bit CMD0 payload 40 00 00 00 00 -> crc_o = 7'h4A; serial output 1001010.
- LANES=4, dir=1, len=4096, all ones, with the correct CRC fed back except one flipped bit on lane 2 -> crc_err_lane = 4'b0100, crc_ok = 0.
- len=0, dir=0 -> crc_o = 0; 16 zero bits on every lane; done after 16 bit slots.
- bit_en asserted on every third cycle plus spurious start pulses mid-block -> results identical to the contiguous run; start ignored.
- rst asserted at data bit 100 -> immediate IDLE, all outputs at reset values, no done; a fresh start then yields a correct CRC.

Source files
------------

// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg
// Shared types and constants for the SD multi-lane CRC block.
//   state_t     : CRC sequencer states
//   CRC16_POLY  : SD data-line CRC-16-CCITT polynomial (x^16 term implied)
//   CRC7_POLY   : SD command-line CRC-7 polynomial (x^7 term implied)
//   DIR_TX/RX   : encoding of the dir input
package sd_crc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        CRC_TX = 3'd2,
        CRC_RX = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [6:0]  CRC7_POLY  = 7'h09;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

endpackage

// File: rtl/sd_crc_lfsr.sv
// sd_crc_lfsr
// One lane of the serial CRC. Zero initial value, MSB-first.
// Ports:
//   sd_clk  : SD bit clock
//   rst     : asynchronous active-high reset (clears the register)
//   clr     : synchronous clear, highest priority
//   step    : absorb bit_in into the CRC
//   shift   : shift the register left, filling with 0 (serialises the CRC)
//   bit_in  : data bit for step
//   crc     : current CRC register
module sd_crc_lfsr #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(16'h1021)
) (
    input  logic             sd_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic             shift,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic inv;

    assign inv = bit_in ^ crc[CRC_W-1];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (step) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (inv ? POLY : '0);
        end else if (shift) begin
            crc <= {crc[CRC_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes
// Multi-lane SD CRC generator/checker with its own CRC-phase sequencing.
// After len data bits per lane it either transmits each lane's CRC MSB-first
// (dir = 0) or compares the incoming CRC bits and flags mismatching lanes
// (dir = 1), then pulses done for one cycle.
// Ports:
//   sd_clk, rst   : SD bit clock, asynchronous active-high reset
//   start         : begin a block (accepted only in IDLE)
//   dir, len      : sampled at start; direction and data bits per lane
//   bit_en        : marks the current cycle as a bit slot
//   dat_i         : per-lane line/payload bits
//   dat_o, dat_oe : line drive value and output enable
//   busy, done    : not-idle flag, end-of-block pulse
//   crc_ok        : all lanes matched (rx) / always 1 (tx), valid from done
//   crc_err_lane  : sticky per-lane mismatch flags (rx)
//   crc_o         : per-lane CRC latched at end of data, lane l at [l*CRC_W +: CRC_W]
module sd_crc_lanes
    import sd_crc_pkg::*;
#(
    parameter int               LANES = 4,
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_POLY),
    parameter int               LEN_W = 13
) (
    input  logic                   sd_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   dir,
    input  logic [LEN_W-1:0]       len,
    input  logic                   bit_en,
    input  logic [LANES-1:0]       dat_i,
    output logic [LANES-1:0]       dat_o,
    output logic                   dat_oe,
    output logic                   busy,
    output logic                   done,
    output logic                   crc_ok,
    output logic [LANES-1:0]       crc_err_lane,
    output logic [LANES*CRC_W-1:0] crc_o
);

    localparam int              CCNT_W    = $clog2(CRC_W + 1);
    localparam logic [CCNT_W-1:0] CCNT_LOAD = CCNT_W'(CRC_W);

    state_t                   state;
    logic                     dir_q;
    logic [LEN_W-1:0]         cnt;
    logic [CCNT_W-1:0]        ccnt;

    logic                     lfsr_clr;
    logic                     lfsr_step;
    logic                     lfsr_shift;
    logic [LANES-1:0]         crc_msb;
    logic [LANES-1:0]         mism;
    // Post-step LFSR values, so crc_o can capture the result of the last data
    // bit on the same edge that absorbs it.
    logic [LANES*CRC_W-1:0]   crc_next;

    assign lfsr_clr   = (state == IDLE) && start;
    assign lfsr_step  = (state == DATA) && bit_en;
    assign lfsr_shift = ((state == CRC_TX) || (state == CRC_RX)) && bit_en;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CRC_W-1:0] lane_crc;
        logic             inv;

        sd_crc_lfsr #(
            .CRC_W (CRC_W),
            .POLY  (POLY)
        ) u_lfsr (
            .sd_clk (sd_clk),
            .rst    (rst),
            .clr    (lfsr_clr),
            .step   (lfsr_step),
            .shift  (lfsr_shift),
            .bit_in (dat_i[l]),
            .crc    (lane_crc)
        );

        assign crc_msb[l] = lane_crc[CRC_W-1];
        assign inv        = dat_i[l] ^ lane_crc[CRC_W-1];
        assign crc_next[l*CRC_W +: CRC_W] = {lane_crc[CRC_W-2:0], 1'b0} ^ (inv ? POLY : '0);
    end

    // In CRC_RX the register MSB is the CRC bit expected on the line this slot.
    assign mism = dat_i ^ crc_msb;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path through
    // the branches can leave one unassigned and infer a latch.
    always_comb begin
        dat_o  = '1;
        dat_oe = 1'b0;
        if ((state == DATA) && (dir_q == DIR_TX)) begin
            dat_o  = dat_i;
            dat_oe = 1'b1;
        end else if (state == CRC_TX) begin
            dat_o  = crc_msb;
            dat_oe = 1'b1;
        end
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            dir_q        <= DIR_TX;
            cnt          <= '0;
            ccnt         <= '0;
            crc_o        <= '0;
            crc_err_lane <= '0;
            crc_ok       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q        <= dir;
                        cnt          <= len;
                        ccnt         <= CCNT_LOAD;
                        crc_err_lane <= '0;
                        if (len != '0) begin
                            state <= DATA;
                        end else begin
                            // Empty block: the CRC of nothing is the cleared LFSR.
                            crc_o <= '0;
                            state <= (dir == DIR_RX) ? CRC_RX : CRC_TX;
                        end
                    end
                end

                DATA: begin
                    if (bit_en) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            crc_o <= crc_next;
                            ccnt  <= CCNT_LOAD;
                            state <= (dir_q == DIR_RX) ? CRC_RX : CRC_TX;
                        end
                    end
                end

                CRC_TX, CRC_RX: begin
                    if (bit_en) begin
                        if (state == CRC_RX) begin
                            crc_err_lane <= crc_err_lane | mism;
                        end
                        ccnt <= ccnt - CCNT_W'(1);
                        if (ccnt == CCNT_W'(1)) begin
                            state  <= DONE;
                            // Include this slot's compare so crc_ok is valid during DONE.
                            crc_ok <= (state == CRC_RX) ? ~|(crc_err_lane | mism) : 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_crc_lanes.sv
// tb_sd_crc_lanes
// Self-checking bench for sd_crc_lanes: a 4-lane CRC-16 instance exercised with
// random blocks and a 1-lane CRC-7 instance for the command path. Expected CRCs
// come from polynomial long division of the augmented message.
module tb_sd_crc_lanes;
    import sd_crc_pkg::*;

    localparam int LANES = 4;
    localparam int CRC_W = 16;
    localparam int LEN_W = 13;

    logic                   sd_clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   dir;
    logic [LEN_W-1:0]       len;
    logic                   bit_en;
    logic [LANES-1:0]       dat_i;
    logic [LANES-1:0]       dat_o;
    logic                   dat_oe;
    logic                   busy;
    logic                   done;
    logic                   crc_ok;
    logic [LANES-1:0]       crc_err_lane;
    logic [LANES*CRC_W-1:0] crc_o;

    logic       c_start;
    logic       c_dir;
    logic [5:0] c_len;
    logic       c_bit_en;
    logic [0:0] c_dat_i;
    logic [0:0] c_dat_o;
    logic       c_oe;
    logic       c_busy;
    logic       c_done;
    logic       c_ok;
    logic [0:0] c_err;
    logic [6:0] c_crc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sd_clk = ~sd_clk;

    sd_crc_lanes #(
        .LANES (LANES),
        .CRC_W (CRC_W),
        .POLY  (CRC16_POLY),
        .LEN_W (LEN_W)
    ) dut (
        .sd_clk       (sd_clk),
        .rst          (rst),
        .start        (start),
        .dir          (dir),
        .len          (len),
        .bit_en       (bit_en),
        .dat_i        (dat_i),
        .dat_o        (dat_o),
        .dat_oe       (dat_oe),
        .busy         (busy),
        .done         (done),
        .crc_ok       (crc_ok),
        .crc_err_lane (crc_err_lane),
        .crc_o        (crc_o)
    );

    sd_crc_lanes #(
        .LANES (1),
        .CRC_W (7),
        .POLY  (CRC7_POLY),
        .LEN_W (6)
    ) dut_cmd (
        .sd_clk       (sd_clk),
        .rst          (rst),
        .start        (c_start),
        .dir          (c_dir),
        .len          (c_len),
        .bit_en       (c_bit_en),
        .dat_i        (c_dat_i),
        .dat_o        (c_dat_o),
        .dat_oe       (c_oe),
        .busy         (c_busy),
        .done         (c_done),
        .crc_ok       (c_ok),
        .crc_err_lane (c_err),
        .crc_o        (c_crc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Remainder of M(x) * x^w divided by G(x): shift message bits then w zeros
    // through a (w+1)-bit window, subtracting G whenever the top term appears.
    function automatic int unsigned ref_crc(input logic [7:0] bits[$], input int lane,
                                            input int w, input int unsigned poly);
        int unsigned r;
        int unsigned top;
        r   = 0;
        top = 32'd1 << w;
        foreach (bits[i]) begin
            r = (r << 1) | 32'(bits[i][lane]);
            if ((r & top) != 0) r = r ^ (top | poly);
        end
        for (int i = 0; i < w; i++) begin
            r = r << 1;
            if ((r & top) != 0) r = r ^ (top | poly);
        end
        return r;
    endfunction

    // bit_en cadence: gap 0 = random, otherwise one slot every gap cycles.
    function automatic logic slot(input int gap, input int cyc);
        if (gap == 0) return 1'($urandom_range(0, 1));
        return (cyc % gap) == 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   busy,         1'b0);
        check({tag, "_done"},   done,         1'b0);
        check({tag, "_oe"},     dat_oe,       1'b0);
        check({tag, "_dat_o"},  dat_o,        {LANES{1'b1}});
        check({tag, "_crc_o"},  crc_o,        '0);
        check({tag, "_err"},    crc_err_lane, '0);
        check({tag, "_crc_ok"}, crc_ok,       1'b1);
    endtask

    task automatic run_block(input logic d, input int n, input bit ones, input int gap,
                             input bit spurious, input int flip_lane, input int flip_bit,
                             input int abort_at);
        logic [7:0]       dq[$];
        int unsigned      exp_crc[LANES];
        logic [LANES-1:0] ebits;
        logic [LANES-1:0] emask;
        logic             en;
        int               k, j, cyc, bad, guard, budget, seen;

        for (int i = 0; i < n; i++) dq.push_back(ones ? 8'hFF : 8'($urandom));
        for (int l = 0; l < LANES; l++) exp_crc[l] = ref_crc(dq, l, CRC_W, CRC16_POLY);
        emask  = (d == DIR_RX && flip_lane >= 0) ? LANES'(1 << flip_lane) : '0;
        budget = 4 * (n + CRC_W) + 64;

        // Start cycle also carries bit_en and junk data: it must not be absorbed.
        @(negedge sd_clk);
        start  = 1'b1;
        dir    = d;
        len    = LEN_W'(n);
        bit_en = 1'b1;
        dat_i  = LANES'($urandom);
        @(negedge sd_clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);

        k = 0; cyc = 0; bad = 0; guard = 0;
        while (k < n && guard < budget) begin
            en     = slot(gap, cyc);
            bit_en = en;
            dat_i  = en ? dq[k][LANES-1:0] : LANES'($urandom);
            start  = spurious && ($urandom_range(0, 7) == 0);
            dir    = start ? ~d : d;
            len    = LEN_W'($urandom_range(1, 20));
            #1;
            if (d == DIR_TX) begin
                if (dat_o !== dat_i || dat_oe !== 1'b1) bad++;
            end else begin
                if (dat_o !== {LANES{1'b1}} || dat_oe !== 1'b0) bad++;
            end
            if (done !== 1'b0 || busy !== 1'b1) bad++;
            if (en && k == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(negedge sd_clk);
                rst = 1'b0; start = 1'b0; bit_en = 1'b0;
                seen = 0;
                repeat (CRC_W + 8) begin
                    bit_en = 1'b1;
                    @(negedge sd_clk);
                    if (done !== 1'b0 || busy !== 1'b0) seen++;
                end
                bit_en = 1'b0;
                check("abort_no_done", seen, 0);
                return;
            end
            @(negedge sd_clk);
            if (en) k++;
            cyc++; guard++;
        end
        start = 1'b0; dir = d;
        check("data_budget", guard < budget, 1'b1);
        check("data_phase", bad, 0);
        for (int l = 0; l < LANES; l++) check("crc_o_lane", crc_o[l*CRC_W +: CRC_W], exp_crc[l]);

        j = 0; bad = 0; guard = 0;
        while (j < CRC_W && guard < budget) begin
            en = slot(gap, cyc);
            for (int l = 0; l < LANES; l++) ebits[l] = exp_crc[l][CRC_W-1-j];
            bit_en = en;
            start  = spurious && ($urandom_range(0, 7) == 0);
            dir    = start ? ~d : d;
            dat_i  = (d == DIR_RX) ? (ebits ^ ((j == flip_bit) ? emask : '0)) : LANES'($urandom);
            #1;
            if (d == DIR_TX) begin
                if (dat_o !== ebits || dat_oe !== 1'b1) bad++;
            end else begin
                if (dat_o !== {LANES{1'b1}} || dat_oe !== 1'b0) bad++;
            end
            if (done !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge sd_clk);
            if (en) j++;
            cyc++; guard++;
        end
        check("crc_budget", guard < budget, 1'b1);
        check("crc_phase", bad, 0);

        // DONE cycle: a start here must be ignored.
        bit_en = 1'($urandom_range(0, 1));
        start  = 1'b1;
        dir    = ~d;
        #1;
        check("done_pulse", done, 1'b1);
        check("done_crc_ok", crc_ok, (d == DIR_RX) ? (emask == '0) : 1'b1);
        check("done_err_lane", crc_err_lane, emask);
        check("done_line", {dat_oe, dat_o}, {1'b0, {LANES{1'b1}}});
        @(negedge sd_clk);
        start = 1'b0; bit_en = 1'b0; dir = d;
        #1;
        check("after_done_idle", {done, busy}, 2'b00);
        check("after_done_err", crc_err_lane, emask);
    endtask

    task automatic run_cmd();
        logic [39:0] payload;
        logic [7:0]  q[$];
        logic [6:0]  ser;
        int unsigned e;
        payload = 40'h40_0000_0000;
        for (int i = 39; i >= 0; i--) q.push_back({7'd0, payload[i]});
        e = ref_crc(q, 0, 7, CRC7_POLY);

        @(negedge sd_clk);
        c_start = 1'b1; c_dir = DIR_TX; c_len = 6'd40; c_bit_en = 1'b0;
        @(negedge sd_clk);
        c_start = 1'b0; c_bit_en = 1'b1;
        for (int i = 39; i >= 0; i--) begin
            c_dat_i = payload[i];
            @(negedge sd_clk);
        end
        check("cmd_crc_o", c_crc, 7'h4A);
        check("cmd_crc_model", c_crc, e);
        ser = '0;
        for (int i = 0; i < 7; i++) begin
            c_dat_i = 1'b0;
            #1;
            ser = {ser[5:0], c_dat_o[0]};
            @(negedge sd_clk);
        end
        check("cmd_serial", ser, 7'b1001010);
        #1;
        check("cmd_done", c_done, 1'b1);
        c_bit_en = 1'b0;
        @(negedge sd_clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; len = '0; bit_en = 1'b0; dat_i = '0;
        c_start = 1'b0; c_dir = 1'b0; c_len = '0; c_bit_en = 1'b0; c_dat_i = '0;
        repeat (3) @(negedge sd_clk);
        check_reset_outputs("reset");
        check("reset_cmd_busy", c_busy, 1'b0);
        rst = 1'b0;

        run_block(DIR_TX, 4096, 1'b1, 1, 1'b0, -1, 0, -1);
        check("ccitt_all_ones", crc_o, {4{16'h7FA1}});

        run_cmd();

        run_block(DIR_RX, 4096, 1'b1, 1, 1'b0, 2, int'($urandom_range(0, 15)), -1);

        run_block(DIR_TX, 0, 1'b0, 1, 1'b0, -1, 0, -1);
        check("len0_crc_o", crc_o, '0);
        run_block(DIR_RX, 0, 1'b0, 2, 1'b1, -1, 0, -1);

        run_block(DIR_TX, 200, 1'b0, 3, 1'b1, -1, 0, -1);
        run_block(DIR_RX, 200, 1'b0, 3, 1'b1, 1, 5, -1);

        run_block(DIR_TX, 300, 1'b0, 1, 1'b0, -1, 0, 100);
        run_block(DIR_TX, 300, 1'b0, 1, 1'b0, -1, 0, -1);

        for (int t = 0; t < 8; t++) begin
            run_block(1'($urandom_range(0, 1)), int'($urandom_range(1, 300)), 1'b0,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 15)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
